// File: rtl/sh_frame_ctrl_if.sv
// sh_frame_ctrl_if: bit-strobe input and frame handshake bundle for sh_frame_ctrl.
// Latency: none, signal bundle only.
// Backpressure: downstream tx_rdy holds a finished frame; the bit source is never stalled.
interface sh_frame_ctrl_if #(
  parameter int FRAME_BITS = 64
);
  localparam int IDX_W = $clog2(FRAME_BITS);

  logic             RX;
  logic             sh_en;
  logic             bit_in;
  logic             tx_rdy;
  logic             buf_sh;
  logic             buf_clr;
  logic             frame_valid;
  logic             frame_err;
  logic [1:0]       err_code;
  logic [IDX_W-1:0] bit_idx;
  logic             busy;

  // Environment side: bit source plus downstream ready
  modport master (
    output RX, sh_en, bit_in, tx_rdy,
    input  buf_sh, buf_clr, frame_valid, frame_err, err_code, bit_idx, busy
  );

  // Sequencer side
  modport slave (
    input  RX, sh_en, bit_in, tx_rdy,
    output buf_sh, buf_clr, frame_valid, frame_err, err_code, bit_idx, busy
  );
endinterface

// File: rtl/sh_frame_ctrl.sv
// sh_frame_ctrl: preamble hunt, gated frame shift, on-the-fly sync check, frame handoff.
// Latency: buf_sh follows sh_en combinationally; frame_valid/frame_err 2 clk after the last strobe.
// Backpressure: frame held in HOLD until tx_rdy; strobes ignored meanwhile. Macro FRAME_CTRL_TIMEOUT_EN adds a strobe-gap watchdog.
module sh_frame_ctrl #(
  parameter int                    FRAME_BITS = 64,
  parameter int                    PRE_LEN    = 8,
  parameter logic [FRAME_BITS-1:0] SYNC_MASK  = 64'h7C00_001F_0000_0000,
  parameter logic [FRAME_BITS-1:0] SYNC_VAL   = 64'h7C00_001F_0000_0000
`ifdef FRAME_CTRL_TIMEOUT_EN
  , parameter int                  TIMEOUT_CYC = 15000
`endif
) (
  input logic            clk,
  input logic            rst,
  sh_frame_ctrl_if.slave sh
);
  localparam int               IDX_W    = $clog2(FRAME_BITS);
  localparam int               PC_W     = $clog2(PRE_LEN + 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_BITS - 1);
  localparam logic [PC_W-1:0]  PRE_LAST = PC_W'(PRE_LEN - 1);
`ifdef FRAME_CTRL_TIMEOUT_EN
  localparam int               GAP_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(TIMEOUT_CYC - 1);
`endif

  typedef enum logic [2:0] {ST_IDLE, ST_HUNT, ST_COLLECT, ST_CHECK, ST_HOLD} state_t;

  state_t           r_state, w_state;
  logic [PC_W-1:0]  r_pre_cnt, w_pre_cnt;
  logic [IDX_W-1:0] r_bit_idx, w_bit_idx;
  logic             r_err, w_err;
  logic             r_buf_clr, w_buf_clr;
  logic             r_frame_err, w_frame_err;
  logic [1:0]       r_err_code, w_err_code;
  logic             r_frame_valid;
  logic             r_busy;
`ifdef FRAME_CTRL_TIMEOUT_EN
  // Counts clocks elapsed since the cycle of the last strobe (the strobe edge itself counts as 1)
  logic [GAP_W-1:0] r_gap, w_gap;
`endif

  // Next-state and next-output decode; every target defaulted first
  always_comb begin
    w_state     = r_state;
    w_pre_cnt   = r_pre_cnt;
    w_bit_idx   = r_bit_idx;
    w_err       = r_err;
    w_buf_clr   = 1'b0;
    w_frame_err = 1'b0;
    w_err_code  = r_err_code;
`ifdef FRAME_CTRL_TIMEOUT_EN
    w_gap       = r_gap;
`endif
    unique case (r_state)
      ST_IDLE: begin
        if (sh.RX) begin
          w_state   = ST_HUNT;
          w_buf_clr = 1'b1;
          w_pre_cnt = '0;
        end
      end
      ST_HUNT: begin
        if (!sh.RX) begin
          w_state   = ST_IDLE;
          w_buf_clr = 1'b1;
          w_pre_cnt = '0;
        end else if (sh.sh_en) begin
          if (!sh.bit_in) begin
            w_pre_cnt = '0;
          end else if (r_pre_cnt == PRE_LAST) begin
            // The completing preamble strobe is consumed here, not shifted
            w_state   = ST_COLLECT;
            w_pre_cnt = '0;
            w_bit_idx = IDX_LAST;
            w_err     = 1'b0;
`ifdef FRAME_CTRL_TIMEOUT_EN
            w_gap     = GAP_W'(1);
`endif
          end else begin
            w_pre_cnt = r_pre_cnt + PC_W'(1);
          end
        end
      end
      ST_COLLECT: begin
        if (!sh.RX) begin
          // Abort beats a simultaneous last strobe
          w_state   = ST_IDLE;
          w_buf_clr = 1'b1;
          w_bit_idx = IDX_LAST;
        end else if (sh.sh_en) begin
          if (SYNC_MASK[r_bit_idx] && (sh.bit_in != SYNC_VAL[r_bit_idx]))
            w_err = 1'b1;
          if (r_bit_idx == '0) begin
            w_state   = ST_CHECK;
            w_bit_idx = IDX_LAST;
          end else begin
            w_bit_idx = r_bit_idx - IDX_W'(1);
          end
`ifdef FRAME_CTRL_TIMEOUT_EN
          w_gap = GAP_W'(1);
        end else if (r_gap == GAP_LAST) begin
          // Gap reaches TIMEOUT_CYC on this edge; RX is known high here
          w_state     = ST_HUNT;
          w_frame_err = 1'b1;
          w_err_code  = 2'b10;
          w_buf_clr   = 1'b1;
          w_bit_idx   = IDX_LAST;
        end else begin
          w_gap = r_gap + GAP_W'(1);
`endif
        end
      end
      ST_CHECK: begin
        if (r_err) begin
          w_state     = sh.RX ? ST_HUNT : ST_IDLE;
          w_frame_err = 1'b1;
          w_err_code  = 2'b01;
          w_buf_clr   = 1'b1;
        end else begin
          w_state = ST_HOLD;
        end
      end
      ST_HOLD: begin
        // frame_valid is high throughout HOLD, so tx_rdy alone completes the transfer
        if (sh.tx_rdy) begin
          w_state   = sh.RX ? ST_HUNT : ST_IDLE;
          w_buf_clr = 1'b1;
        end
      end
      default: begin
        w_state   = ST_IDLE;
        w_bit_idx = IDX_LAST;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_pre_cnt     <= '0;
      r_bit_idx     <= IDX_LAST;
      r_err         <= 1'b0;
      r_buf_clr     <= 1'b0;
      r_frame_err   <= 1'b0;
      r_err_code    <= 2'b00;
      r_frame_valid <= 1'b0;
      r_busy        <= 1'b0;
`ifdef FRAME_CTRL_TIMEOUT_EN
      r_gap         <= '0;
`endif
    end else begin
      r_state       <= w_state;
      r_pre_cnt     <= w_pre_cnt;
      r_bit_idx     <= w_bit_idx;
      r_err         <= w_err;
      r_buf_clr     <= w_buf_clr;
      r_frame_err   <= w_frame_err;
      r_err_code    <= w_err_code;
      r_frame_valid <= (w_state == ST_HOLD);
      r_busy        <= (w_state != ST_IDLE);
`ifdef FRAME_CTRL_TIMEOUT_EN
      r_gap         <= w_gap;
`endif
    end
  end

  assign sh.buf_sh      = sh.sh_en && (r_state == ST_COLLECT);
  assign sh.buf_clr     = r_buf_clr;
  assign sh.frame_valid = r_frame_valid;
  assign sh.frame_err   = r_frame_err;
  assign sh.err_code    = r_err_code;
  assign sh.bit_idx     = r_bit_idx;
  assign sh.busy        = r_busy;
endmodule

// File: doc/sh_frame_ctrl.md
# sh_frame_ctrl

Receive-frame sequencer between SH_SYNC and the shift buffer. It takes SH_SYNC's per-bit strobe (`sh_en`) and the sampled bit, and hunts for the all-ones preamble. It then gates exactly FRAME_BITS shifts into the buffer, checks the fixed sync fields on the fly, and hands a good frame downstream with a valid/ready handshake on `tx_rdy`. An optional watchdog aborts frames whose bit strobes stop arriving.

## Interface
- FRAME_BITS, 64, payload bits shifted per frame (MSB first, index FRAME_BITS-1 down to 0)
- PRE_LEN, 8, consecutive 1-bits required to declare preamble
- SYNC_MASK, 64'h7C00_001F_0000_0000, bit positions checked (62..58, 36..32)
- SYNC_VAL, 64'h7C00_001F_0000_0000, required values at masked positions
- TIMEOUT_CYC, 15000, max clk cycles between strobes while collecting (1.5 bit periods at 10 MHz/1 kbps)
- clk  in  1  system clock
- rst  in  1  reset; one clock, asynchronous, active-high
- RX  in  1  receive mode enable
- sh_en  in  1  one-cycle bit strobe from SH_SYNC
- bit_in  in  1  bit value, valid when sh_en=1
- tx_rdy  in  1  downstream ready to accept frame
- buf_sh  out  1  gated shift enable to buffer (= sh_en in COLLECT)
- buf_clr  out  1  one-cycle buffer clear pulse
- frame_valid  out  1  buffer holds a checked frame
- frame_err  out  1  one-cycle error pulse
- err_code  out  2  01 sync mismatch, 10 timeout, held until next frame_err
- bit_idx  out  $clog2(FRAME_BITS)  index of next bit to be shifted
- busy  out  1  state != IDLE

## Operation
- States: IDLE, HUNT, COLLECT, CHECK, HOLD.
- IDLE: if RX=1, pulse buf_clr, clear preamble count, go HUNT.
- HUNT: on sh_en, bit_in=1 increments pre_cnt, bit_in=0 clears it. The strobe that makes pre_cnt=PRE_LEN goes to COLLECT with bit_idx=FRAME_BITS-1 and err=0; that strobe itself is not shifted. Extra preamble 1s beyond PRE_LEN are frame bits.
- COLLECT: each sh_en asserts buf_sh the same cycle. If SYNC_MASK[bit_idx]=1 and bit_in!=SYNC_VAL[bit_idx], set sticky err. Decrement bit_idx. The strobe at bit_idx=0 goes to CHECK.
- CHECK (one cycle): err=1 gives frame_err=1, err_code=01, buf_clr=1, then HUNT if RX else IDLE. err=0 gives HOLD.
- HOLD: frame_valid=1; sh_en is ignored and buf_sh=0. The transfer occurs when frame_valid and tx_rdy are both 1 on a clock edge. After transfer, frame_valid=0, pulse buf_clr, go HUNT if RX else IDLE.
- RX drop: in HUNT or COLLECT, RX=0 aborts to IDLE with buf_clr pulse and no frame_err. In HOLD, RX is ignored and the frame is still delivered.
- Simultaneous events: RX=0 with the last COLLECT strobe means the abort wins. sh_en in the cycle the timeout would fire means the strobe wins and the gap counter resets.
- bit_idx is held at FRAME_BITS-1 outside COLLECT.

## Timing
- Reset values: buf_sh=0, buf_clr=0, frame_valid=0, frame_err=0, err_code=00, bit_idx=FRAME_BITS-1, busy=0, state=IDLE.
- buf_sh is combinational from sh_en and state, giving zero latency. All other outputs are registered.
- Last strobe to CHECK is 1 clk; to frame_valid is 2 clk; to frame_err is 2 clk.
- frame_valid deasserts the clk after the transfer edge. Back-to-back frames are allowed once HUNT is re-entered.
- Reset mid-frame returns every output to its reset value immediately.

## Configuration
- FRAME_CTRL_TIMEOUT_EN defined: a gap counter of $clog2(TIMEOUT_CYC+1) bits runs in COLLECT and clears on sh_en. At TIMEOUT_CYC it fires frame_err=1, err_code=10 and buf_clr, then goes to HUNT if RX else IDLE.
- FRAME_CTRL_TIMEOUT_EN undefined: no counter exists, COLLECT waits indefinitely, and err_code=10 never occurs.

## Test plan
- Good frame: RX=1, 8 ones, then 64 bits with 1s at 62..58 and 36..32, tx_rdy=1 -> 64 buf_sh pulses, frame_valid for 1 clk, no frame_err.
- Sync error: same frame with bit 60=0 -> frame_err 2 clk after the last strobe, err_code=01, buf_clr pulse, back in HUNT, frame_valid stays 0.
- Preamble restart: send 1,1,1,0 then 8 ones -> COLLECT entered only after the 8th consecutive one; bit_idx=63 at entry.
- Backpressure: good frame with tx_rdy=0 for 50 clk -> frame_valid held and buf_sh=0 despite sh_en. Raise tx_rdy -> transfer, then frame_valid=0 next clk.
- Timeout (macro on): stop strobes after bit 40 -> frame_err and err_code=10 exactly 15000 clk after the last strobe. With the macro off -> state stays COLLECT.
- Abort/reset: RX=0 at bit 20 -> IDLE, buf_clr, no frame_err. Reset asserted in HOLD -> frame_valid=0 asynchronously.
